// File: rtl/fake_memory_latency_if.sv
// fake_memory_latency_if
//   Request/response bundle for the multi-channel memory timing model.
//   master : the core side (drives requests, consumes responses)
//   slave  : the memory model side
//   Signals:
//     req_valid  [NCH]          per-channel request valid
//     req_ready  [NCH]          per-channel request ready
//     req_addr   [NCH*ADDR_W]   channel c address at [c*ADDR_W +: ADDR_W]
//     rsp_valid  [NCH]          per-channel response valid
//     rsp_ready  [NCH]          per-channel response ready
//     rsp_data   [NCH*DATA_W]   channel c data at [c*DATA_W +: DATA_W]
//     stall_inj                 injected stall for the current cycle
interface fake_memory_latency_if #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
);
  logic [NCH-1:0]        req_valid;
  logic [NCH-1:0]        req_ready;
  logic [NCH*ADDR_W-1:0] req_addr;
  logic [NCH-1:0]        rsp_valid;
  logic [NCH-1:0]        rsp_ready;
  logic [NCH*DATA_W-1:0] rsp_data;
  logic                  stall_inj;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, stall_inj
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, stall_inj
  );
endinterface

// File: rtl/fake_memory_latency.sv
// fake_memory_latency
//   Multi-channel memory timing model. Each channel accepts read requests
//   over valid/ready and returns address-derived data LATENCY cycles later
//   through a non-collapsing shift pipeline that stalls as a whole under
//   response back-pressure. A shared 16-bit Fibonacci LFSR can inject
//   request-side stalls (JITTER=1).
//   Ports:
//     clk    rising-edge clock
//     rst_b  asynchronous active-low reset
//     mem    request/response bundle (slave side)
module fake_memory_latency #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned JITTER  = 0,
  parameter logic [31:0] SEED    = 32'hA5A5_0F0F
) (
  input  logic                  clk,
  input  logic                  rst_b,
  fake_memory_latency_if.slave  mem
);

  // Scramble constant rotated left by the channel index, so each channel
  // returns a distinct pattern for the same address.
  function automatic logic [DATA_W-1:0] rol_seed(input int unsigned ch);
    logic [DATA_W-1:0] s;
    int unsigned       k;
    s = DATA_W'(SEED);
    k = ch % DATA_W;
    if (k == 0) begin
      return s;
    end
    return (s << k) | (s >> (DATA_W - k));
  endfunction

  logic [LATENCY-1:0] stg_v  [NCH];
  logic [DATA_W-1:0]  stg_d  [NCH][LATENCY];
  logic [7:0]         cnt    [NCH];
  logic [15:0]        lfsr;

  logic               stall;
  logic [NCH-1:0]     adv;
  logic [NCH-1:0]     acc;
  logic [DATA_W-1:0]  load_d [NCH];

  // Per-channel advance/accept decisions and the value loaded on accept.
  always_comb begin
    stall  = (JITTER != 0) ? lfsr[0] : 1'b0;
    adv    = '0;
    acc    = '0;
    load_d = '{default: '0};
    for (int unsigned c = 0; c < NCH; c++) begin
      // The whole channel pipeline moves unless a held response blocks the head.
      adv[c]    = !stg_v[c][LATENCY-1] | mem.rsp_ready[c];
      acc[c]    = mem.req_valid[c] & adv[c] & !stall;
      load_d[c] = (DATA_W'(mem.req_addr[c*ADDR_W +: ADDR_W]) ^ rol_seed(c))
                  + DATA_W'(cnt[c]);
    end
  end

  // Outputs come straight from the last pipeline stage, so response data
  // stays stable for as long as the head is held.
  always_comb begin
    mem.req_ready = adv & {NCH{!stall}};
    mem.stall_inj = stall;
    mem.rsp_valid = '0;
    mem.rsp_data  = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      mem.rsp_valid[c]                 = stg_v[c][LATENCY-1];
      mem.rsp_data[c*DATA_W +: DATA_W] = stg_d[c][LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lfsr <= 16'hACE1;
      for (int unsigned c = 0; c < NCH; c++) begin
        stg_v[c] <= '0;
        cnt[c]   <= '0;
        for (int unsigned s = 0; s < LATENCY; s++) begin
          stg_d[c][s] <= '0;
        end
      end
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      for (int unsigned c = 0; c < NCH; c++) begin
        if (adv[c]) begin
          // Bubbles shift along with valid entries; nothing is collapsed.
          for (int unsigned s = 1; s < LATENCY; s++) begin
            stg_v[c][s] <= stg_v[c][s-1];
            stg_d[c][s] <= stg_d[c][s-1];
          end
          stg_v[c][0] <= acc[c];
          stg_d[c][0] <= acc[c] ? load_d[c] : '0;
        end
        if (acc[c]) begin
          cnt[c] <= cnt[c] + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fake_memory_latency.sv
module tb_fake_memory_latency;

  localparam int LAT [3] = '{2, 3, 2};
  localparam int JIT [3] = '{0, 0, 1};

  logic clk;
  logic rst_b;

  logic [3:0]  in_valid  [3];
  logic [29:0] in_addr   [3][4];
  logic [3:0]  in_rready [3];

  logic [3:0]  obs_rdy [3];
  logic [3:0]  obs_rv  [3];
  logic [31:0] obs_rd  [3][4];
  logic        obs_st  [3];

  logic [31:0] md  [3][4][$];
  int          mr  [3][4][$];
  logic [31:0] got [3][4][$];
  int          m_cnt  [3][4];
  logic [15:0] m_lfsr [3];

  int n_tests;
  int n_fail;

  fake_memory_latency_if #(.NCH(4), .ADDR_W(30), .DATA_W(32)) if_a ();
  fake_memory_latency_if #(.NCH(4), .ADDR_W(30), .DATA_W(32)) if_b ();
  fake_memory_latency_if #(.NCH(4), .ADDR_W(30), .DATA_W(32)) if_c ();

  fake_memory_latency #(.NCH(4), .ADDR_W(30), .DATA_W(32), .LATENCY(2), .JITTER(0),
                        .SEED(32'hA5A5_0F0F))
    dut_a (.clk(clk), .rst_b(rst_b), .mem(if_a));
  fake_memory_latency #(.NCH(4), .ADDR_W(30), .DATA_W(32), .LATENCY(3), .JITTER(0),
                        .SEED(32'hA5A5_0F0F))
    dut_b (.clk(clk), .rst_b(rst_b), .mem(if_b));
  fake_memory_latency #(.NCH(4), .ADDR_W(30), .DATA_W(32), .LATENCY(2), .JITTER(1),
                        .SEED(32'hA5A5_0F0F))
    dut_c (.clk(clk), .rst_b(rst_b), .mem(if_c));

  always_comb begin
    if_a.req_valid = in_valid[0];
    if_a.rsp_ready = in_rready[0];
    if_a.req_addr  = {in_addr[0][3], in_addr[0][2], in_addr[0][1], in_addr[0][0]};
    if_b.req_valid = in_valid[1];
    if_b.rsp_ready = in_rready[1];
    if_b.req_addr  = {in_addr[1][3], in_addr[1][2], in_addr[1][1], in_addr[1][0]};
    if_c.req_valid = in_valid[2];
    if_c.rsp_ready = in_rready[2];
    if_c.req_addr  = {in_addr[2][3], in_addr[2][2], in_addr[2][1], in_addr[2][0]};
  end

  always_comb begin
    obs_rdy[0] = if_a.req_ready;  obs_rv[0] = if_a.rsp_valid;  obs_st[0] = if_a.stall_inj;
    obs_rdy[1] = if_b.req_ready;  obs_rv[1] = if_b.rsp_valid;  obs_st[1] = if_b.stall_inj;
    obs_rdy[2] = if_c.req_ready;  obs_rv[2] = if_c.rsp_valid;  obs_st[2] = if_c.stall_inj;
    for (int c = 0; c < 4; c++) begin
      obs_rd[0][c] = if_a.rsp_data[c*32 +: 32];
      obs_rd[1][c] = if_b.rsp_data[c*32 +: 32];
      obs_rd[2][c] = if_c.rsp_data[c*32 +: 32];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int d, input int c,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d ch%0d observed=%h expected=%h", tag, d, c, obs, exp);
    end
  endtask

  // Expected response word: address xor the channel-rotated seed, plus the
  // per-channel accept count.
  function automatic logic [31:0] exp_data(input int c, input logic [29:0] a, input int n);
    logic [31:0] s;
    logic [31:0] r;
    s = 32'hA5A5_0F0F;
    r = (c == 0) ? s : ((s << c) | (s >> (32 - c)));
    return ({2'b00, a} ^ r) + 32'(n);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_lfsr[d] = 16'hACE1;
      for (int c = 0; c < 4; c++) begin
        md[d][c].delete();
        mr[d][c].delete();
        got[d][c].delete();
        m_cnt[d][c] = 0;
      end
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 4'h0;
      in_rready[d] = 4'hF;
      for (int c = 0; c < 4; c++) in_addr[d][c] = '0;
    end
  endtask

  task automatic reset_checks();
    for (int d = 0; d < 3; d++) begin
      chk("rst_rsp_valid", d, 0, 32'(obs_rv[d]), 32'h0);
      chk("rst_req_ready", d, 0, 32'(obs_rdy[d]), (JIT[d] != 0) ? 32'h0 : 32'hF);
      chk("rst_stall_inj", d, 0, 32'(obs_st[d]), 32'(JIT[d]));
      for (int c = 0; c < 4; c++) chk("rst_rsp_data", d, c, obs_rd[d][c], 32'h0);
    end
  endtask

  // Assert reset asynchronously (away from any clock edge), check, then
  // release it just after a rising edge.
  task automatic do_reset();
    rst_b = 1'b0;
    #1;
    reset_checks();
    model_reset();
    @(posedge clk);
    #1;
    rst_b = 1'b1;
  endtask

  // One clock cycle: compare all outputs at the falling edge against the
  // model, then advance the model across the following rising edge.
  // Each in-flight entry carries the number of advancing edges it still
  // needs before it becomes the visible response.
  task automatic cycle();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      logic stall;
      stall = (JIT[d] != 0) && m_lfsr[d][0];
      chk("stall_inj", d, 0, 32'(obs_st[d]), 32'(stall));
      for (int c = 0; c < 4; c++) begin
        logic head;
        logic adv;
        logic acc;
        head = (mr[d][c].size() > 0) && (mr[d][c][0] == 0);
        adv  = !head || in_rready[d][c];
        acc  = in_valid[d][c] && adv && !stall;
        chk("req_ready", d, c, 32'(obs_rdy[d][c]), 32'(adv && !stall));
        chk("rsp_valid", d, c, 32'(obs_rv[d][c]), 32'(head));
        if (head) chk("rsp_data", d, c, obs_rd[d][c], md[d][c][0]);
        if (adv) begin
          if (head) begin
            got[d][c].push_back(obs_rd[d][c]);
            void'(md[d][c].pop_front());
            void'(mr[d][c].pop_front());
          end
          for (int i = 0; i < mr[d][c].size(); i++) begin
            if (mr[d][c][i] > 0) mr[d][c][i] = mr[d][c][i] - 1;
          end
          if (acc) begin
            md[d][c].push_back(exp_data(c, in_addr[d][c], m_cnt[d][c]));
            mr[d][c].push_back(LAT[d] - 1);
            m_cnt[d][c] = (m_cnt[d][c] + 1) % 256;
          end
        end
      end
      m_lfsr[d] = {m_lfsr[d][14:0], m_lfsr[d][15] ^ m_lfsr[d][13] ^ m_lfsr[d][12] ^ m_lfsr[d][10]};
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_all();
    model_reset();
    rst_b = 1'b1;
    #2;
    do_reset();

    // Single request on dut_a ch0, addr 0x10.
    in_valid[0] = 4'b0001;
    in_addr[0][0] = 30'h10;
    cycle();
    idle_all();
    repeat (4) cycle();
    chk("single_count", 0, 0, 32'(got[0][0].size()), 32'd1);
    chk("single_data", 0, 0, got[0][0][0], 32'hA5A5_0F1F);

    // Four back-to-back requests on dut_a ch1, the last to addr 0x10.
    for (int i = 0; i < 4; i++) begin
      in_valid[0] = 4'b0010;
      in_addr[0][1] = (i == 3) ? 30'h10 : 30'(i + 1);
      cycle();
    end
    idle_all();
    repeat (4) cycle();
    chk("b2b_count", 0, 1, 32'(got[0][1].size()), 32'd4);
    chk("b2b_fourth", 0, 1, got[0][1][3], 32'h4B4A_1E12);

    // dut_b (LATENCY=3): fill ch0 under back-pressure, hold, then drain,
    // with random traffic on ch2 throughout.
    in_rready[1] = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      in_valid[1] = 4'b0001 | {1'b0, 1'($urandom), 2'b00};
      in_addr[1][0] = 30'(i + 1) << 8;
      in_addr[1][2] = 30'($urandom);
      cycle();
    end
    in_addr[1][0] = 30'h3FF;
    for (int i = 0; i < 5; i++) begin
      chk("full_req_ready", 1, 0, 32'(obs_rdy[1][0]), 32'h0);
      chk("full_rsp_valid", 1, 0, 32'(obs_rv[1][0]), 32'h1);
      chk("full_head", 1, 0, obs_rd[1][0], exp_data(0, 30'h100, 0));
      in_valid[1] = 4'b0001 | {1'b0, 1'($urandom), 2'b00};
      in_addr[1][2] = 30'($urandom);
      cycle();
    end
    idle_all();
    repeat (6) cycle();
    chk("drain_count", 1, 0, 32'(got[1][0].size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("drain_order", 1, 0, got[1][0][i], exp_data(0, 30'(i + 1) << 8, i));

    // Reset with two requests in flight on dut_a ch0.
    in_rready[0] = 4'b1110;
    in_valid[0] = 4'b0001;
    in_addr[0][0] = 30'h40;
    repeat (2) cycle();
    in_valid[0] = 4'b0000;
    chk("inflight_valid", 0, 0, 32'(obs_rv[0][0]), 32'h1);
    do_reset();
    in_rready[0] = 4'hF;
    in_valid[0] = 4'b0001;
    in_addr[0][0] = 30'h10;
    cycle();
    idle_all();
    repeat (4) cycle();
    chk("post_rst_count", 0, 0, 32'(got[0][0].size()), 32'd1);
    chk("post_rst_data", 0, 0, got[0][0][0], 32'hA5A5_0F1F);

    // 257 accepts on dut_a ch0 at addr 0: count wraps 255 -> 0.
    do_reset();
    in_valid[0] = 4'b0001;
    in_addr[0][0] = '0;
    repeat (257) cycle();
    idle_all();
    repeat (4) cycle();
    chk("wrap_count", 0, 0, 32'(got[0][0].size()), 32'd257);
    chk("wrap_255", 0, 0, got[0][0][255], 32'hA5A5_100E);
    chk("wrap_256", 0, 0, got[0][0][256], 32'hA5A5_0F0F);

    // Random traffic on every channel of every instance (dut_c has jitter).
    do_reset();
    for (int i = 0; i < 300; i++) begin
      for (int d = 0; d < 3; d++) begin
        in_valid[d]  = 4'($urandom);
        in_rready[d] = 4'($urandom) | 4'($urandom);
        for (int c = 0; c < 4; c++) in_addr[d][c] = 30'($urandom);
      end
      cycle();
    end
    idle_all();
    repeat (12) cycle();
    for (int d = 0; d < 3; d++)
      chk("final_idle", d, 0, 32'(obs_rv[d]), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
